// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a simple request/ack data bus.
// Handles lane selection, alignment checks, extension of load data and bus timeouts.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       alu_data_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              done_o,
    output logic              stallreq_o,
    output logic [1:0]        exc_o,
    output logic [ADDR_W-1:0] bad_addr_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic                wreg_lat_q, wreg_lat_d;
    logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [31:0]         bwdata_q, bwdata_d;
    logic [4:0]          wd_q, wd_d;
    logic                wreg_q, wreg_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic [1:0]          exc_q, exc_d;
    logic [ADDR_W-1:0]   bad_q, bad_d;

    logic        is_byte, is_half, is_word, is_store, is_mem, aligned;
    logic [1:0]  lane_idx;
    logic        half_hi;
    logic [3:0]  be_c;
    logic [31:0] st_wdata_c;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    // Request decode: size, alignment and lane mapping
    always_comb begin
        is_byte  = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
        is_half  = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
        is_word  = (op_i == OP_LW) || (op_i == OP_SW);
        is_store = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW);
        is_mem   = is_byte || is_half || is_word;
        aligned  = is_byte || (is_half && !addr_i[0]) || (is_word && (addr_i[1:0] == 2'b00));
        lane_idx = (BIG_ENDIAN != 0) ? ~addr_i[1:0] : addr_i[1:0];
        half_hi  = (BIG_ENDIAN != 0) ? ~addr_i[1] : addr_i[1];
        be_c       = 4'b1111;
        st_wdata_c = st_data_i;
        if (is_byte) begin
            be_c       = 4'b0001 << lane_idx;
            st_wdata_c = {4{st_data_i[7:0]}};
        end else if (is_half) begin
            be_c       = half_hi ? 4'b1100 : 4'b0011;
            st_wdata_c = {2{st_data_i[15:0]}};
        end
    end

    // Extract the read lanes recorded at acceptance and extend per load type
    always_comb begin
        case (be_q)
            4'b0010: rd_byte = bus_rdata_i[15:8];
            4'b0100: rd_byte = bus_rdata_i[23:16];
            4'b1000: rd_byte = bus_rdata_i[31:24];
            default: rd_byte = bus_rdata_i[7:0];
        endcase
        rd_half = be_q[3] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_val = {24'd0, rd_byte};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'd0, rd_half};
            OP_LW:   load_val = bus_rdata_i;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        wreg_lat_d = wreg_lat_q;
        addr_lat_d = addr_lat_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        baddr_d    = baddr_q;
        bwdata_d   = bwdata_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        exc_d      = exc_q;
        bad_d      = bad_q;
        stallreq_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid_i) begin
                    wd_d = wd_i;
                    if (!is_mem) begin
                        wreg_d  = wreg_i;
                        wdata_d = alu_data_i;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (!aligned) begin
                        wreg_d  = 1'b0;
                        wdata_d = '0;
                        exc_d   = 2'b01;
                        bad_d   = addr_i;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        stallreq_o = 1'b1;
                        op_d       = op_i;
                        wreg_lat_d = wreg_i;
                        addr_lat_d = addr_i;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        we_d       = is_store;
                        be_d       = be_c;
                        baddr_d    = {addr_i[ADDR_W-1:2], 2'b00};
                        bwdata_d   = is_store ? st_wdata_c : '0;
                        state_d    = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stallreq_o = 1'b1;
                if (bus_ack_i) begin
                    req_d   = 1'b0;
                    wreg_d  = wreg_lat_q;
                    wdata_d = load_val;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    wreg_d  = 1'b0;
                    wdata_d = '0;
                    exc_d   = 2'b10;
                    bad_d   = addr_lat_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                done_d  = 1'b0;
                exc_d   = '0;
                bad_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            wreg_lat_q <= 1'b0;
            addr_lat_q <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            baddr_q    <= '0;
            bwdata_q   <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            exc_q      <= '0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            wreg_lat_q <= wreg_lat_d;
            addr_lat_q <= addr_lat_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            baddr_q    <= baddr_d;
            bwdata_q   <= bwdata_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            bad_q      <= bad_d;
        end
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_be_o    = be_q;
    assign bus_addr_o  = baddr_q;
    assign bus_wdata_o = bwdata_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign done_o      = done_q;
    assign exc_o       = exc_q;
    assign bad_addr_o  = bad_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: big-endian/TIMEOUT=4 instance (a) and
// little-endian/default instance (b) driven with identical stimulus.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] alu_data;
    logic        ack;
    logic [31:0] rdata;

    logic        a_req, a_we, a_wreg, a_done, a_stall;
    logic [3:0]  a_be;
    logic [31:0] a_baddr, a_bwdata, a_wdata, a_bad;
    logic [4:0]  a_wd;
    logic [1:0]  a_exc;

    logic        b_req, b_we, b_wreg, b_done, b_stall;
    logic [3:0]  b_be;
    logic [31:0] b_baddr, b_bwdata, b_wdata, b_bad;
    logic [4:0]  b_wd;
    logic [1:0]  b_exc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(4)) u_a (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op), .addr_i(addr),
        .st_data_i(st_data), .wd_i(wd), .wreg_i(wreg), .alu_data_i(alu_data),
        .bus_req_o(a_req), .bus_we_o(a_we), .bus_be_o(a_be), .bus_addr_o(a_baddr),
        .bus_wdata_o(a_bwdata), .bus_ack_i(ack), .bus_rdata_i(rdata),
        .wd_o(a_wd), .wreg_o(a_wreg), .wdata_o(a_wdata), .done_o(a_done),
        .stallreq_o(a_stall), .exc_o(a_exc), .bad_addr_o(a_bad)
    );

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(16)) u_b (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op), .addr_i(addr),
        .st_data_i(st_data), .wd_i(wd), .wreg_i(wreg), .alu_data_i(alu_data),
        .bus_req_o(b_req), .bus_we_o(b_we), .bus_be_o(b_be), .bus_addr_o(b_baddr),
        .bus_wdata_o(b_bwdata), .bus_ack_i(ack), .bus_rdata_i(rdata),
        .wd_o(b_wd), .wreg_o(b_wreg), .wdata_o(b_wdata), .done_o(b_done),
        .stallreq_o(b_stall), .exc_o(b_exc), .bad_addr_o(b_bad)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] d, input logic w, input logic [31:0] alu);
        op_valid = 1'b1;
        op       = o;
        addr     = a;
        st_data  = sd;
        wd       = d;
        wreg     = w;
        alu_data = alu;
        #1;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = '0; addr = '0; st_data = '0;
        wd = '0; wreg = 1'b0; alu_data = '0; ack = 1'b0; rdata = '0;
        step();
        step();
        chk("rst_req",   {31'd0, a_req}, 32'd0);
        chk("rst_be",    {28'd0, a_be}, 32'd0);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_done",  {31'd0, a_done}, 32'd0);
        chk("rst_exc",   {30'd0, a_exc}, 32'd0);
        chk("rst_stall", {31'd0, a_stall}, 32'd0);
        rst = 1'b0;
        step();

        // LB 0x102, ack in first BUSY cycle
        issue(4'd1, 32'h102, 32'h0, 5'd5, 1'b1, 32'h0);
        chk("lb_stall_idle", {31'd0, a_stall}, 32'd1);
        step();
        chk("lb_req",    {31'd0, a_req}, 32'd1);
        chk("lb_we",     {31'd0, a_we}, 32'd0);
        chk("lb_be_a",   {28'd0, a_be}, 32'h2);
        chk("lb_be_b",   {28'd0, b_be}, 32'h4);
        chk("lb_addr",   a_baddr, 32'h100);
        chk("lb_stall",  {31'd0, a_stall}, 32'd1);
        chk("lb_done0",  {31'd0, a_done}, 32'd0);
        ack = 1'b1; rdata = 32'h1122F344;
        step();
        chk("lb_done",    {31'd0, a_done}, 32'd1);
        chk("lb_wdata_a", a_wdata, 32'hFFFFFFF3);
        chk("lb_wdata_b", b_wdata, 32'h00000022);
        chk("lb_wreg",    {31'd0, a_wreg}, 32'd1);
        chk("lb_wd",      {27'd0, a_wd}, 32'd5);
        chk("lb_req_off", {31'd0, a_req}, 32'd0);
        chk("lb_exc",     {30'd0, a_exc}, 32'd0);
        op_valid = 1'b0; ack = 1'b0;
        step();
        chk("lb_done_pulse", {31'd0, a_done}, 32'd0);

        // SH 0x206 store, checked mainly on the little-endian instance
        issue(4'd7, 32'h206, 32'hAAAA5678, 5'd3, 1'b0, 32'h0);
        step();
        chk("sh_we",      {31'd0, b_we}, 32'd1);
        chk("sh_be_b",    {28'd0, b_be}, 32'hC);
        chk("sh_be_a",    {28'd0, a_be}, 32'h3);
        chk("sh_wdata",   b_bwdata, 32'h56785678);
        chk("sh_addr",    b_baddr, 32'h204);
        step();
        chk("sh_held_be",  {28'd0, b_be}, 32'hC);
        chk("sh_held_req", {31'd0, b_req}, 32'd1);
        ack = 1'b1;
        step();
        chk("sh_done", {31'd0, b_done}, 32'd1);
        chk("sh_wreg", {31'd0, b_wreg}, 32'd0);
        op_valid = 1'b0; ack = 1'b0;
        step();

        // SW store with wreg_i latched high
        issue(4'd8, 32'h600, 32'h12345678, 5'd9, 1'b1, 32'h0);
        step();
        chk("sw_be",    {28'd0, a_be}, 32'hF);
        chk("sw_wdata", a_bwdata, 32'h12345678);
        ack = 1'b1;
        step();
        chk("sw_wreg", {31'd0, a_wreg}, 32'd1);
        op_valid = 1'b0; ack = 1'b0;
        step();

        // LH sign extension, ack on the second BUSY cycle
        issue(4'd3, 32'h100, 32'h0, 5'd4, 1'b1, 32'h0);
        step();
        chk("lh_be_a", {28'd0, a_be}, 32'hC);
        step();
        ack = 1'b1; rdata = 32'h80011234;
        step();
        chk("lh_wdata_a", a_wdata, 32'hFFFF8001);
        chk("lh_wdata_b", b_wdata, 32'h00001234);
        op_valid = 1'b0; ack = 1'b0;
        step();

        // Non-memory op (undefined encoding treated as NOP)
        issue(4'd12, 32'h3, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF);
        chk("nop_stall", {31'd0, a_stall}, 32'd0);
        step();
        chk("nop_done",  {31'd0, a_done}, 32'd1);
        chk("nop_wdata", a_wdata, 32'hDEADBEEF);
        chk("nop_wd",    {27'd0, a_wd}, 32'd7);
        chk("nop_req",   {31'd0, a_req}, 32'd0);
        op_valid = 1'b0;
        step();

        // Misaligned LW 0x301
        issue(4'd5, 32'h301, 32'h0, 5'd2, 1'b1, 32'h0);
        chk("mis_stall0", {31'd0, a_stall}, 32'd0);
        step();
        chk("mis_done",   {31'd0, a_done}, 32'd1);
        chk("mis_exc",    {30'd0, a_exc}, 32'd1);
        chk("mis_bad",    a_bad, 32'h301);
        chk("mis_wreg",   {31'd0, a_wreg}, 32'd0);
        chk("mis_req",    {31'd0, a_req}, 32'd0);
        chk("mis_stall1", {31'd0, a_stall}, 32'd0);
        op_valid = 1'b0;
        step();
        chk("mis_exc_clr", {30'd0, a_exc}, 32'd0);
        chk("mis_bad_clr", a_bad, 32'd0);

        // LHU 0x400, no ack: timeout after 4 BUSY cycles on instance a
        issue(4'd4, 32'h400, 32'h0, 5'd6, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to_req%0d", i), {31'd0, a_req}, 32'd1);
        end
        step();
        chk("to_done", {31'd0, a_done}, 32'd1);
        chk("to_exc",  {30'd0, a_exc}, 32'd2);
        chk("to_bad",  a_bad, 32'h400);
        chk("to_wreg", {31'd0, a_wreg}, 32'd0);
        chk("to_req_off", {31'd0, a_req}, 32'd0);
        op_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // LW with reset during the second BUSY cycle, late ack ignored
        issue(4'd5, 32'h500, 32'h0, 5'd8, 1'b1, 32'h0);
        step();
        step();
        chk("rb_req_busy", {31'd0, a_req}, 32'd1);
        rst = 1'b1;
        step();
        chk("rb_req_rst",  {31'd0, a_req}, 32'd0);
        chk("rb_done_rst", {31'd0, a_done}, 32'd0);
        rst = 1'b0; op_valid = 1'b0; ack = 1'b1; rdata = 32'hCAFEF00D;
        step();
        chk("rb_done_ack",  {31'd0, a_done}, 32'd0);
        chk("rb_req_ack",   {31'd0, a_req}, 32'd0);
        chk("rb_wdata_ack", a_wdata, 32'd0);
        chk("rb_stall_ack", {31'd0, a_stall}, 32'd0);
        ack = 1'b0;
        step();
        chk("rb_done_late", {31'd0, a_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
